// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: default operand width and FSM state encoding shared by the divider files.
package seq_divider_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_CALC = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/seq_divider_div_restore_step.sv
// seq_divider_div_restore_step: one combinational radix-2 restoring step on magnitudes.
module seq_divider_div_restore_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ok;

  // One extra bit: the borrow of the trial subtract lands in the msb.
  assign w_shift = {rem_in, quo_in[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, divisor};
  assign w_ok    = ~w_diff[WIDTH];

  assign rem_out = w_ok ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], w_ok};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: valid/ready radix-2 restoring divider, RISC-V DIV/DIVU/REM/REMU; WIDTH+2 edges, 1 for special cases.
// One op in flight, result held in DONE until result_ready; SEQ_DIVIDER_EARLY_OUT_EN skips leading zeros of |a|.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] aOperand,
  input  logic [WIDTH-1:0] bOperand,
  input  logic             unsignedEn,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] divResult,
  output logic [WIDTH-1:0] remResult,
  output logic             divByZero
);

  localparam int                CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_uns;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_last;
  logic [WIDTH-1:0] r_div_res;
  logic [WIDTH-1:0] r_rem_res;
  logic             r_dbz;

  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic             w_ovf;
  logic             w_a_zero;
  logic [WIDTH-1:0] w_quo_init;
  logic [CW-1:0]    w_last;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  assign w_sign_a = r_a[WIDTH-1] & ~r_uns;
  assign w_sign_b = r_b[WIDTH-1] & ~r_uns;
  assign w_abs_a  = w_sign_a ? (~r_a + ONE) : r_a;
  assign w_abs_b  = w_sign_b ? (~r_b + ONE) : r_b;
  assign w_ovf    = w_sign_a && (r_a == MIN) && (r_b == '1);

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  logic [CW-1:0] w_lz;
  logic          w_seen;

  always_comb begin
    w_lz   = '0;
    w_seen = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_abs_a[i]) w_seen = 1'b1;
      else if (!w_seen) w_lz = w_lz + CW'(1);
    end
  end

  // Pre-shifting past the zero msbs leaves only WIDTH-n meaningful steps.
  assign w_a_zero   = (r_a == '0);
  assign w_quo_init = w_abs_a << w_lz;
  assign w_last     = LAST - w_lz;
`else
  assign w_a_zero   = 1'b0;
  assign w_quo_init = w_abs_a;
  assign w_last     = LAST;
`endif

  seq_divider_div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (r_rem),
    .quo_in (r_quo),
    .divisor(r_b),
    .rem_out(w_rem_next),
    .quo_out(w_quo_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= DIV_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_uns     <= 1'b0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_last    <= '0;
      r_div_res <= '0;
      r_rem_res <= '0;
      r_dbz     <= 1'b0;
    end else if (flush) begin
      r_state <= DIV_IDLE;
    end else begin
      unique case (r_state)
        DIV_IDLE: begin
          if (start_valid) begin
            r_a     <= aOperand;
            r_b     <= bOperand;
            r_uns   <= unsignedEn;
            r_state <= DIV_PREP;
          end
        end
        DIV_PREP: begin
          r_sign_a <= w_sign_a;
          r_sign_b <= w_sign_b;
          if (r_b == '0) begin
            r_div_res <= '1;
            r_rem_res <= r_a;
            r_dbz     <= 1'b1;
            r_state   <= DIV_DONE;
          end else if (w_ovf) begin
            r_div_res <= MIN;
            r_rem_res <= '0;
            r_dbz     <= 1'b0;
            r_state   <= DIV_DONE;
          end else if (w_a_zero) begin
            r_div_res <= '0;
            r_rem_res <= '0;
            r_dbz     <= 1'b0;
            r_state   <= DIV_DONE;
          end else begin
            r_b     <= w_abs_b;
            r_quo   <= w_quo_init;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_last  <= w_last;
            r_state <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == r_last) r_state <= DIV_FIX;
        end
        DIV_FIX: begin
          // Truncating division: quotient sign is the xor, remainder follows the dividend.
          r_div_res <= (r_sign_a ^ r_sign_b) ? (~r_quo + ONE) : r_quo;
          r_rem_res <= r_sign_a ? (~r_rem + ONE) : r_rem;
          r_dbz     <= 1'b0;
          r_state   <= DIV_DONE;
        end
        DIV_DONE: begin
          if (result_ready) r_state <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

  assign start_ready  = (r_state == DIV_IDLE);
  assign result_valid = (r_state == DIV_DONE);
  assign divResult    = r_div_res;
  assign remResult    = r_rem_res;
  assign divByZero    = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors for seq_divider with an arithmetic reference model checked every cycle.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] aOperand;
  logic [31:0] bOperand;
  logic        unsignedEn;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] divResult;
  logic [31:0] remResult;
  logic        divByZero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .aOperand    (aOperand),
    .bOperand    (bOperand),
    .unsignedEn  (unsignedEn),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .divResult   (divResult),
    .remResult   (remResult),
    .divByZero   (divByZero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on the operands, plus the edge count until the result appears.
  function automatic int lead_zeros(input logic [31:0] v);
    int n = 0;
    while (n < 32 && v[31-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic void model_eval(input logic [31:0] a, input logic [31:0] b, input logic uns,
                                     output logic [31:0] q, output logic [31:0] r,
                                     output logic z, output int lat);
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    logic [31:0] mag;
`endif
    z   = 1'b0;
    lat = 34;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1; lat = 1;
    end else if (!uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (uns) begin
      q = a / b; r = a % b;
    end else begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    if (lat != 1) begin
      mag = (!uns && a[31]) ? -a : a;
      if (mag == 32'd0) lat = 1;
      else lat = 34 - lead_zeros(mag);
    end
`endif
  endfunction

  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_q    = '0;
  logic [31:0] m_r    = '0;
  logic        m_z    = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else if (flush) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else if (m_done) begin
      if (result_ready) m_done = 1'b0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin m_busy = 1'b0; m_done = 1'b1; end
    end else if (start_valid) begin
      model_eval(aOperand, bOperand, unsignedEn, m_q, m_r, m_z, m_cnt);
      m_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("cmp.start_ready", 32'(start_ready), 32'(!(m_busy || m_done)));
    check("cmp.result_valid", 32'(result_valid), 32'(m_done));
    if (m_done) begin
      check("cmp.divResult", divResult, m_q);
      check("cmp.remResult", remResult, m_r);
      check("cmp.divByZero", 32'(divByZero), 32'(m_z));
    end
  end

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic uns);
    @(negedge clk);
    check("start.idle", 32'(start_ready), 32'd1);
    aOperand = a; bOperand = b; unsignedEn = uns; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; aOperand = ~a; bOperand = ~b; unsignedEn = ~uns;
  endtask

  task automatic finish_op(input string tag, input logic [31:0] eq, input logic [31:0] er,
                           input logic ez, input int lat_def, input int lat_eo,
                           input int hold, input bit release_it);
    int lat;
    int n = 0;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    lat = lat_eo;
`else
    lat = lat_def;
`endif
    while (!result_valid && n < 100) begin @(posedge clk); #1; n++; end
    check({tag, ".latency"}, 32'(n), 32'(lat));
    check({tag, ".q"}, divResult, eq);
    check({tag, ".r"}, remResult, er);
    check({tag, ".dbz"}, 32'(divByZero), 32'(ez));
    if (hold > 0) begin
      @(negedge clk);
      start_valid = 1'b1; aOperand = 32'd1234; bOperand = 32'd3; unsignedEn = 1'b1;
      repeat (hold - 1) @(negedge clk);
      start_valid = 1'b0;
      check({tag, ".hold_busy"}, 32'(start_ready), 32'd0);
      check({tag, ".hold_valid"}, 32'(result_valid), 32'd1);
      check({tag, ".hold_q"}, divResult, eq);
      check({tag, ".hold_r"}, remResult, er);
    end
    if (release_it) begin
      @(negedge clk); result_ready = 1'b1;
      @(negedge clk); result_ready = 1'b0;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic uns,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez,
                       input int lat_def, input int lat_eo, input int hold);
    start_op(a, b, uns);
    finish_op(tag, eq, er, ez, lat_def, lat_eo, hold, 1'b1);
  endtask

  initial begin
    reset_n = 1'b1; flush = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
    aOperand = '0; bOperand = '0; unsignedEn = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("reset.start_ready", 32'(start_ready), 32'd1);
    check("reset.result_valid", 32'(result_valid), 32'd0);
    check("reset.divResult", divResult, 32'd0);
    check("reset.remResult", remResult, 32'd0);
    check("reset.divByZero", 32'(divByZero), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    //     tag         a             b             uns   q             r             z    lat  eo  hold
    do_op("udiv",     32'd100,      32'd7,        1'b1, 32'd14,       32'd2,        1'b0, 34, 9,  0);
    do_op("sdiv_m7",  32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, 5,  10);
    do_op("dz_s",     32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1,  1,  0);
    do_op("dz_u",     32'd5,        32'd0,        1'b1, 32'hFFFFFFFF, 32'd5,        1'b1, 1,  1,  0);
    do_op("dz_neg",   32'hFFFFFFF9, 32'd0,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1,  1,  0);
    do_op("ovf",      32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'd0,        1'b0, 1,  1,  0);
    do_op("u_min",    32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0,        32'h80000000, 1'b0, 34, 34, 0);
    do_op("sneg_a",   32'hFFFFFF9C, 32'd7,        1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, 9,  0);
    do_op("sneg_b",   32'd100,      32'hFFFFFFF9, 1'b0, 32'hFFFFFFF2, 32'd2,        1'b0, 34, 9,  0);
    do_op("umax",     32'hFFFFFFFF, 32'd1,        1'b1, 32'hFFFFFFFF, 32'd0,        1'b0, 34, 34, 0);
    do_op("small",    32'd7,        32'd100,      1'b1, 32'd0,        32'd7,        1'b0, 34, 5,  0);
    do_op("smin2",    32'h80000000, 32'd2,        1'b0, 32'hC0000000, 32'd0,        1'b0, 34, 34, 0);
    do_op("zero_a",   32'd0,        32'd5,        1'b1, 32'd0,        32'd0,        1'b0, 34, 1,  0);

    // Consume and offer a new op in the same DONE cycle: the new op is taken one cycle later.
    start_op(32'd100, 32'd7, 1'b1);
    finish_op("pre_chain", 32'd14, 32'd2, 1'b0, 34, 9, 0, 1'b0);
    @(negedge clk);
    result_ready = 1'b1; start_valid = 1'b1; aOperand = 32'd50; bOperand = 32'd5; unsignedEn = 1'b1;
    @(posedge clk); #1;
    check("chain.wait", 32'(start_ready), 32'd1);
    result_ready = 1'b0;
    @(posedge clk); #1;
    check("chain.accept", 32'(start_ready), 32'd0);
    start_valid = 1'b0; aOperand = 32'd0; bOperand = 32'd0;
    finish_op("chain", 32'd10, 32'd0, 1'b0, 34, 8, 0, 1'b1);

    // Flush at CALC iteration 10: no result, back to IDLE on the next edge.
    start_op(32'h7FFFFFFF, 32'd3, 1'b1);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush.idle", 32'(start_ready), 32'd1);
    check("flush.no_valid", 32'(result_valid), 32'd0);
    repeat (40) @(negedge clk);
    check("flush.still_no_valid", 32'(result_valid), 32'd0);
    do_op("after_flush", 32'd1000, 32'd3, 1'b1, 32'd333, 32'd1, 1'b0, 34, 12, 0);

    // Flush wins over an accept in IDLE.
    @(negedge clk);
    start_valid = 1'b1; flush = 1'b1; aOperand = 32'd9; bOperand = 32'd3; unsignedEn = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0; flush = 1'b0;
    check("flush_vs_accept", 32'(start_ready), 32'd1);

    // Asynchronous reset between edges while in CALC.
    start_op(32'h7FFFFFFF, 32'd3, 1'b1);
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("areset.start_ready", 32'(start_ready), 32'd1);
    check("areset.result_valid", 32'(result_valid), 32'd0);
    check("areset.divResult", divResult, 32'd0);
    check("areset.remResult", remResult, 32'd0);
    check("areset.divByZero", 32'(divByZero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    do_op("after_reset", 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 34, 9, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
